// File: rtl/add16_pg_if.sv
// add16_pg_if: operand/result bundle for the add16_pg lookahead adder.
//   a, b  : 16-bit operands (driven by master)
//   cin   : carry into bit 0 (driven by master)
//   s     : registered 16-bit sum (driven by slave)
//   PG    : registered block propagate (driven by slave)
//   GG    : registered block generate (driven by slave)
interface add16_pg_if;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        PG;
    logic        GG;

    modport master (output a, b, cin, input s, PG, GG);
    modport slave  (input a, b, cin, output s, PG, GG);
endinterface

// File: rtl/add16_pg.sv
// add16_pg: 16-bit two-level carry-lookahead adder (4 groups of 4 bits)
// with registered sum and registered block propagate/generate, so it can
// sit under a higher-level lookahead unit. One clock of latency, full
// throughput. Carry-out is not produced; the parent computes GG | PG&cin.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset (s, PG, GG cleared)
//   bus   : add16_pg_if slave modport (a, b, cin in; s, PG, GG out)
module add16_pg #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    add16_pg_if.slave  bus
);

    localparam int NGRP = WIDTH / GROUP;

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] c;
    logic [NGRP-1:0]  gp;
    logic [NGRP-1:0]  gg;
    logic [NGRP-1:0]  gc;
    logic [WIDTH-1:0] sum_n;
    logic             pg_n;
    logic             gg_n;

    always_comb begin
        p = bus.a ^ bus.b;
        g = bus.a & bus.b;

        // First level: group propagate/generate, 4-bit lookahead form.
        for (int unsigned k = 0; k < NGRP; k++) begin
            gp[k] = &p[k*GROUP +: GROUP];
            gg[k] = g[k*GROUP+3]
                  | (p[k*GROUP+3] & g[k*GROUP+2])
                  | (p[k*GROUP+3] & p[k*GROUP+2] & g[k*GROUP+1])
                  | (p[k*GROUP+3] & p[k*GROUP+2] & p[k*GROUP+1] & g[k*GROUP]);
        end

        // Second level: carries into each group from group terms and cin.
        gc[0] = bus.cin;
        gc[1] = gg[0] | (gp[0] & bus.cin);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & bus.cin);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & bus.cin);

        // Carries inside each group, expanded from the group carry-in.
        for (int unsigned k = 0; k < NGRP; k++) begin
            c[k*GROUP]   = gc[k];
            c[k*GROUP+1] = g[k*GROUP] | (p[k*GROUP] & gc[k]);
            c[k*GROUP+2] = g[k*GROUP+1]
                         | (p[k*GROUP+1] & g[k*GROUP])
                         | (p[k*GROUP+1] & p[k*GROUP] & gc[k]);
            c[k*GROUP+3] = g[k*GROUP+2]
                         | (p[k*GROUP+2] & g[k*GROUP+1])
                         | (p[k*GROUP+2] & p[k*GROUP+1] & g[k*GROUP])
                         | (p[k*GROUP+2] & p[k*GROUP+1] & p[k*GROUP] & gc[k]);
        end

        sum_n = p ^ c;

        // Block terms are independent of cin.
        pg_n = &gp;
        gg_n = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
             | (gp[3] & gp[2] & gp[1] & gg[0]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.s  <= '0;
            bus.PG <= 1'b0;
            bus.GG <= 1'b0;
        end else begin
            bus.s  <= sum_n;
            bus.PG <= pg_n;
            bus.GG <= gg_n;
        end
    end

endmodule

// File: tb/tb_add16_pg.sv
// tb_add16_pg: directed self-checking bench for add16_pg, followed by a
// short run of random vectors checked against an arithmetic model.
module tb_add16_pg;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    add16_pg_if bus ();

    add16_pg #(.WIDTH(16), .GROUP(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply operands away from the clock edge, then sample just after the
    // capturing edge.
    task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic cin);
        @(negedge clk);
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
        @(posedge clk);
        #1;
    endtask

    task automatic vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic [15:0] s_exp,
                       input logic pg_exp, input logic gg_exp);
        apply(a, b, cin);
        chk({tag, ".s"},  bus.s, s_exp);
        chk({tag, ".PG"}, {15'd0, bus.PG}, {15'd0, pg_exp});
        chk({tag, ".GG"}, {15'd0, bus.GG}, {15'd0, gg_exp});
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [16:0] full;
        logic [16:0] nocin;
        logic        pg_e;

        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        bus.a   = 16'h0000;
        bus.b   = 16'h0000;
        bus.cin = 1'b0;

        // Reset held for two cycles with operands that would carry.
        vec("rst0", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0);
        vec("rst1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        vec("rel",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1);

        // Full propagate, with and without carry in.
        vec("prop0", 16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        vec("prop1", 16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Group boundaries.
        vec("grp4",  16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0);
        vec("grp12", 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);
        vec("msb",   16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b1);
        vec("grp8",  16'h00FF, 16'h0001, 1'b1, 16'h0101, 1'b0, 1'b0);

        // Zero and identity.
        vec("zero", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        vec("id",   16'h1234, 16'h0000, 1'b0, 16'h1234, 1'b0, 1'b0);

        // Back-to-back operands, one result per cycle.
        vec("pipe0", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);
        vec("pipe1", 16'h0003, 16'h0004, 1'b1, 16'h0008, 1'b0, 1'b0);
        vec("pipe2", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b0, 1'b1);

        // Reset in mid-stream overrides live operands.
        @(negedge clk);
        rst_n = 1'b0;
        vec("rst2", 16'h7FFF, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random vectors against the arithmetic reference.
        for (int i = 0; i < 400; i++) begin
            ra    = 16'($urandom);
            rb    = 16'($urandom);
            rc    = 1'($urandom_range(1, 0));
            full  = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            nocin = {1'b0, ra} + {1'b0, rb};
            pg_e  = ((ra ^ rb) == 16'hFFFF);
            apply(ra, rb, rc);
            chk("rnd.s",  bus.s, full[15:0]);
            chk("rnd.PG", {15'd0, bus.PG}, {15'd0, pg_e});
            chk("rnd.GG", {15'd0, bus.GG}, {15'd0, nocin[16]});
            chk("rnd.co", {15'd0, bus.GG | (bus.PG & rc)}, {15'd0, full[16]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
